// File: rtl/eth_phy_10g_pkg.sv
// Shared constants and types for the 10GBASE-R RX alignment path.
package eth_phy_10g_pkg;

  localparam int         BLOCK_WIDTH  = 66;
  localparam int         OFFSET_MAX   = 65;
  localparam int         OFFSET_WIDTH = 7;
  localparam logic [1:0] SYNC_DATA    = 2'b10;
  localparam logic [1:0] SYNC_CTRL    = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } slip_state_t;

  // Window offset advance with wrap from the last bit position back to 0.
  function automatic logic [OFFSET_WIDTH-1:0] next_offset(input logic [OFFSET_WIDTH-1:0] off);
    return (off == OFFSET_WIDTH'(OFFSET_MAX)) ? '0 : off + 1'b1;
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_bitslip_if.sv
// Gearbox-to-PHY alignment bus: raw words and slip controls in, aligned words and slip status out.
interface eth_phy_10g_rx_bitslip_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
);
  import eth_phy_10g_pkg::*;

  logic [DATA_WIDTH+HDR_WIDTH-1:0] raw_word;
  logic                            raw_valid;
  logic                            serdes_rx_bitslip;
  logic                            serdes_rx_reset_req;
  logic [DATA_WIDTH-1:0]           serdes_rx_data;
  logic [HDR_WIDTH-1:0]            serdes_rx_hdr;
  logic                            serdes_rx_valid;
  logic [OFFSET_WIDTH-1:0]         slip_offset;
  logic                            slip_busy;

  modport master (
    output raw_word, raw_valid, serdes_rx_bitslip, serdes_rx_reset_req,
    input  serdes_rx_data, serdes_rx_hdr, serdes_rx_valid, slip_offset, slip_busy
  );

  modport slave (
    input  raw_word, raw_valid, serdes_rx_bitslip, serdes_rx_reset_req,
    output serdes_rx_data, serdes_rx_hdr, serdes_rx_valid, slip_offset, slip_busy
  );

endinterface

// File: rtl/eth_phy_10g_rx_bitslip_shifter.sv
// Combinational 132->66 window selector: picks cat[offset +: 66], offset 0..65.
module eth_phy_10g_rx_bitslip_shifter
  import eth_phy_10g_pkg::*;
(
  input  logic [2*BLOCK_WIDTH-1:0] cat,
  input  logic [OFFSET_WIDTH-1:0]  offset,
  output logic [BLOCK_WIDTH-1:0]   window
);

  logic [OFFSET_WIDTH:0] base;

  assign base   = {1'b0, offset};
  assign window = cat[base +: BLOCK_WIDTH];

endmodule

// File: rtl/eth_phy_10g_rx_bitslip.sv
// Bitslip responder: slides a 66-bit window over consecutive gearbox words on each accepted slip.
module eth_phy_10g_rx_bitslip
  import eth_phy_10g_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int HDR_WIDTH       = 2,
  parameter int BITSLIP_HOLDOFF = 8,
  parameter bit BIT_REVERSE     = 1'b0
) (
  input logic                     rx_clk,
  input logic                     rx_rst_n,
  eth_phy_10g_rx_bitslip_if.slave bus
);

  localparam int CNT_W = (BITSLIP_HOLDOFF < 1) ? 1 : $clog2(BITSLIP_HOLDOFF + 1);

  logic [BLOCK_WIDTH-1:0]  word_in;
  logic [BLOCK_WIDTH-1:0]  prev_word;
  logic [BLOCK_WIDTH-1:0]  window;
  logic [OFFSET_WIDTH-1:0] offset;
  logic [CNT_W-1:0]        holdoff_cnt;
  logic                    bitslip_d;
  logic                    rise;
  logic                    accept;
  slip_state_t             state;
  slip_state_t             state_next;

  generate
    if (BIT_REVERSE) begin : g_rev
      always_comb begin
        for (int i = 0; i < BLOCK_WIDTH; i++) word_in[i] = bus.raw_word[BLOCK_WIDTH-1-i];
      end
    end else begin : g_fwd
      assign word_in = bus.raw_word;
    end
  endgenerate

  // A level held high counts once; a resync request swallows any coincident rise.
  assign rise   = bus.serdes_rx_bitslip & ~bitslip_d;
  assign accept = rise & (holdoff_cnt == '0) & ~bus.serdes_rx_reset_req;

  eth_phy_10g_rx_bitslip_shifter u_shifter (
    .cat    ({word_in, prev_word}),
    .offset (offset),
    .window (window)
  );

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned and infers a latch.
    state_next = state;
    case (state)
      IDLE:    if (accept && (BITSLIP_HOLDOFF != 0)) state_next = HOLD;
      HOLD:    if (holdoff_cnt == CNT_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.serdes_rx_reset_req) state_next = IDLE;
  end

  always_comb bus.slip_busy = (state == HOLD);

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      offset      <= '0;
      holdoff_cnt <= '0;
      bitslip_d   <= 1'b0;
    end else begin
      bitslip_d <= bus.serdes_rx_bitslip;
      if (bus.serdes_rx_reset_req) begin
        offset      <= '0;
        holdoff_cnt <= '0;
      end else if (accept) begin
        offset      <= next_offset(offset);
        holdoff_cnt <= CNT_W'(BITSLIP_HOLDOFF);
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end
    end
  end

  // Output word uses the offset in force before this edge; a new offset shows up on the next word.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      prev_word           <= '0;
      bus.serdes_rx_data  <= '0;
      bus.serdes_rx_hdr   <= '0;
      bus.serdes_rx_valid <= 1'b0;
    end else begin
      bus.serdes_rx_valid <= bus.raw_valid;
      if (bus.raw_valid) begin
        bus.serdes_rx_hdr  <= window[HDR_WIDTH-1:0];
        bus.serdes_rx_data <= window[HDR_WIDTH +: DATA_WIDTH];
      end
      if (bus.serdes_rx_reset_req) begin
        prev_word <= '0;
      end else if (bus.raw_valid) begin
        prev_word <= word_in;
      end
    end
  end

  assign bus.slip_offset = offset;

endmodule

// File: tb/tb_eth_phy_10g_rx_bitslip.sv
// Directed bench for eth_phy_10g_rx_bitslip: constant vector table plus modelled multi-cycle sequences.
module tb_eth_phy_10g_rx_bitslip;
  import eth_phy_10g_pkg::*;

  localparam int HOLDOFF = 8;

  logic rx_clk   = 1'b0;
  logic rx_rst_n = 1'b1;

  eth_phy_10g_rx_bitslip_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) bus ();

  eth_phy_10g_rx_bitslip #(
    .DATA_WIDTH      (64),
    .HDR_WIDTH       (2),
    .BITSLIP_HOLDOFF (HOLDOFF),
    .BIT_REVERSE     (1'b0)
  ) dut (
    .rx_clk   (rx_clk),
    .rx_rst_n (rx_rst_n),
    .bus      (bus)
  );

  always #5 rx_clk = ~rx_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side model of the block
  logic [65:0] m_prev;
  int          m_off;
  int          m_cnt;
  bit          m_bsd;
  bit          m_valid;
  logic [1:0]  m_hdr;
  logic [63:0] m_data;

  typedef struct {
    logic [65:0] raw;
    bit          valid;
    bit          slip;
    bit          rreq;
    bit          e_valid;
    logic [1:0]  e_hdr;
    logic [63:0] e_data;
    int          e_off;
    bit          e_busy;
  } vec_t;

  vec_t vecs[8];

  localparam logic [65:0] W1 = {64'h0123456789ABCDEF, 2'b01};
  localparam logic [65:0] W2 = {64'hFEDCBA9876543210, 2'b10};
  localparam logic [65:0] W3 = {64'hA5A5A5A5A5A5A5A5, 2'b01};

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [65:0] rand66();
    return {$urandom(), $urandom(), 2'($urandom())};
  endfunction

  // Bit-by-bit window pick from {cur, prv}, bit 0 of prv being the oldest.
  function automatic logic [65:0] ref_window(input logic [65:0] cur, input logic [65:0] prv, input int off);
    logic [65:0] w;
    int idx;
    for (int i = 0; i < 66; i++) begin
      idx  = off + i;
      w[i] = (idx < 66) ? prv[idx] : cur[idx-66];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_prev  = '0;
    m_off   = 0;
    m_cnt   = 0;
    m_bsd   = 1'b0;
    m_valid = 1'b0;
    m_hdr   = '0;
    m_data  = '0;
  endtask

  task automatic do_reset();
    bus.raw_word            = '0;
    bus.raw_valid           = 1'b0;
    bus.serdes_rx_bitslip   = 1'b0;
    bus.serdes_rx_reset_req = 1'b0;
    rx_rst_n = 1'b0;
    @(posedge rx_clk);
    @(negedge rx_clk);
    rx_rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one cycle, advance the model, then compare every output after the edge.
  task automatic cycle(input logic [65:0] raw, input bit valid, input bit slip, input bit rreq,
                       input string tag);
    logic [65:0] w;
    bit          rise;
    bus.raw_word            = raw;
    bus.raw_valid           = valid;
    bus.serdes_rx_bitslip   = slip;
    bus.serdes_rx_reset_req = rreq;
    rise = slip && !m_bsd;
    if (valid) begin
      w      = ref_window(raw, m_prev, m_off);
      m_hdr  = w[1:0];
      m_data = w[65:2];
    end
    m_valid = valid;
    if (rreq) begin
      m_prev = '0;
      m_off  = 0;
      m_cnt  = 0;
    end else begin
      if (valid) m_prev = raw;
      if (rise && m_cnt == 0) begin
        m_off = (m_off == OFFSET_MAX) ? 0 : m_off + 1;
        m_cnt = HOLDOFF;
      end else if (m_cnt > 0) begin
        m_cnt--;
      end
    end
    m_bsd = slip;
    @(posedge rx_clk);
    #1;
    check({tag, "_valid"}, bus.serdes_rx_valid, m_valid);
    if (!(rreq && valid)) begin
      check({tag, "_hdr"}, bus.serdes_rx_hdr, m_hdr);
      check({tag, "_data"}, bus.serdes_rx_data, m_data);
    end
    check({tag, "_offset"}, bus.slip_offset, m_off);
    check({tag, "_busy"}, bus.slip_busy, m_cnt != 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [65:0] blk, blk_prev;
    logic [63:0] held_data;
    logic [1:0]  held_hdr;
    int          busy_cycles;

    vecs[0] = '{W1, 1, 0, 0, 1, 2'b00, 64'h0, 0, 0};
    vecs[1] = '{W2, 1, 0, 0, 1, 2'b01, 64'h0123456789ABCDEF, 0, 0};
    vecs[2] = '{W3, 0, 0, 0, 0, 2'b01, 64'h0123456789ABCDEF, 0, 0};
    vecs[3] = '{W3, 1, 0, 0, 1, 2'b10, 64'hFEDCBA9876543210, 0, 0};
    vecs[4] = '{W1, 1, 1, 0, 1, 2'b01, 64'hA5A5A5A5A5A5A5A5, 1, 1};
    vecs[5] = '{W2, 1, 1, 0, 1, 2'b10, 64'h0091A2B3C4D5E6F7, 1, 1};
    vecs[6] = '{W3, 1, 0, 0, 1, 2'b01, 64'hFF6E5D4C3B2A1908, 1, 1};
    vecs[7] = '{W1, 0, 1, 0, 0, 2'b01, 64'hFF6E5D4C3B2A1908, 1, 1};

    bus.raw_word            = '0;
    bus.raw_valid           = 1'b0;
    bus.serdes_rx_bitslip   = 1'b0;
    bus.serdes_rx_reset_req = 1'b0;
    #2 rx_rst_n = 1'b0;
    @(posedge rx_clk);
    #1;
    check("rst_valid", bus.serdes_rx_valid, 1'b0);
    check("rst_hdr", bus.serdes_rx_hdr, 2'b00);
    check("rst_data", bus.serdes_rx_data, 64'h0);
    check("rst_offset", bus.slip_offset, 7'd0);
    check("rst_busy", bus.slip_busy, 1'b0);
    @(negedge rx_clk);
    rx_rst_n = 1'b1;

    // Vector table: aligned words, a gap, one accepted slip, a discarded rise
    for (int i = 0; i < 8; i++) begin
      bus.raw_word            = vecs[i].raw;
      bus.raw_valid           = vecs[i].valid;
      bus.serdes_rx_bitslip   = vecs[i].slip;
      bus.serdes_rx_reset_req = vecs[i].rreq;
      @(posedge rx_clk);
      #1;
      check($sformatf("tbl%0d_valid", i), bus.serdes_rx_valid, vecs[i].e_valid);
      check($sformatf("tbl%0d_hdr", i), bus.serdes_rx_hdr, vecs[i].e_hdr);
      check($sformatf("tbl%0d_data", i), bus.serdes_rx_data, vecs[i].e_data);
      check($sformatf("tbl%0d_offset", i), bus.slip_offset, vecs[i].e_off);
      check($sformatf("tbl%0d_busy", i), bus.slip_busy, vecs[i].e_busy);
    end

    // Two rises three cycles apart: only the first counts, busy exactly HOLDOFF cycles
    do_reset();
    cycle(rand66(), 1, 0, 0, "t3");
    cycle(rand66(), 1, 0, 0, "t3");
    busy_cycles = 0;
    for (int k = 0; k < 14; k++) begin
      cycle(rand66(), 1, (k == 0) || (k == 3), 0, "t3");
      if (bus.slip_busy) busy_cycles++;
    end
    check("t3_busy_cycles", busy_cycles, HOLDOFF);
    check("t3_offset", bus.slip_offset, 7'd1);

    // Stream misaligned by 5 bits; five slips bring headers into place
    do_reset();
    blk_prev = '0;
    for (int k = 0; k < 120; k++) begin
      blk = {$urandom(), $urandom(), ($urandom_range(0, 1) != 0) ? SYNC_DATA : SYNC_CTRL};
      cycle({blk[60:0], blk_prev[65:61]}, 1, (k % 10 == 3) && (k < 50), 0, "t2");
      if (k == 49) check("t2_offset5", bus.slip_offset, 7'd5);
      if (k >= 55) begin
        check("t2_sync", (bus.serdes_rx_hdr == SYNC_DATA) || (bus.serdes_rx_hdr == SYNC_CTRL), 1'b1);
        check("t2_blk_hdr", bus.serdes_rx_hdr, blk_prev[1:0]);
        check("t2_blk_data", bus.serdes_rx_data, blk_prev[65:2]);
      end
      blk_prev = blk;
    end

    // 66 slips wrap the offset back to 0
    do_reset();
    for (int s = 1; s <= 66; s++) begin
      for (int c = 0; c < 10; c++) cycle(rand66(), 1, c == 0, 0, "t4");
      if (s == 65) check("t4_offset65", bus.slip_offset, 7'd65);
    end
    check("t4_wrap", bus.slip_offset, 7'd0);
    cycle(W1, 1, 0, 0, "t4");
    cycle(W2, 1, 0, 0, "t4");
    check("t4_zero_hdr", bus.serdes_rx_hdr, 2'b01);
    check("t4_zero_data", bus.serdes_rx_data, 64'h0123456789ABCDEF);

    // Resync request coinciding with a slip rise at offset 12
    do_reset();
    for (int s = 0; s < 12; s++) begin
      for (int c = 0; c < 10; c++) cycle(rand66(), 1, c == 0, 0, "t5");
    end
    check("t5_offset12", bus.slip_offset, 7'd12);
    cycle(rand66(), 1, 1, 1, "t5r");
    check("t5r_offset", bus.slip_offset, 7'd0);
    check("t5r_busy", bus.slip_busy, 1'b0);
    cycle(W1, 1, 0, 0, "t5b");
    check("t5b_hdr_cleared", bus.serdes_rx_hdr, 2'b00);
    check("t5b_data_cleared", bus.serdes_rx_data, 64'h0);
    cycle(W2, 1, 0, 0, "t5c");

    // Three-cycle gap, then asynchronous reset between edges
    do_reset();
    cycle(W1, 1, 0, 0, "t6");
    cycle(W2, 1, 1, 0, "t6");
    cycle(W3, 1, 0, 0, "t6");
    held_hdr  = bus.serdes_rx_hdr;
    held_data = bus.serdes_rx_data;
    for (int g = 0; g < 3; g++) begin
      cycle(rand66(), 0, 0, 0, "t6gap");
      check("t6gap_hold_hdr", bus.serdes_rx_hdr, held_hdr);
      check("t6gap_hold_data", bus.serdes_rx_data, held_data);
    end
    #2 rx_rst_n = 1'b0;
    #1;
    check("t6_async_valid", bus.serdes_rx_valid, 1'b0);
    check("t6_async_hdr", bus.serdes_rx_hdr, 2'b00);
    check("t6_async_data", bus.serdes_rx_data, 64'h0);
    check("t6_async_offset", bus.slip_offset, 7'd0);
    check("t6_async_busy", bus.slip_busy, 1'b0);
    bus.serdes_rx_bitslip = 1'b0;
    #2 rx_rst_n = 1'b1;
    model_reset();
    cycle(W1, 1, 0, 0, "t6post");
    check("t6post_hdr", bus.serdes_rx_hdr, 2'b00);
    check("t6post_data", bus.serdes_rx_data, 64'h0);
    cycle(W2, 1, 0, 0, "t6post");
    check("t6post2_data", bus.serdes_rx_data, 64'h0123456789ABCDEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
